// File: rtl/riscv_alu_div_serial.sv
// Serial radix-2 restoring divider for the EX stage.
// Executes DIVU/DIV/REMU/REM with one quotient bit per cycle on operand
// magnitudes, then applies the sign fix-up once when the result is registered.
module riscv_alu_div_serial #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_valid_i,
    input  logic [6:0]        operator_i,
    input  logic [DATA_W-1:0] operand_a_i,
    input  logic [DATA_W-1:0] operand_b_i,
    output logic              div_ready_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    input  logic              ex_ready_i,
    input  logic              kill_i
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    // Upper opcode bits shared by the four divide/remainder operations.
    localparam logic [4:0] DIV_GROUP = 5'b01100;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIV    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Two's complement negation when neg is set, identity otherwise.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] value,
                                                   input logic              neg);
        logic signed [DATA_W-1:0] sval;
        sval = $signed(value);
        return neg ? $unsigned(-sval) : value;
    endfunction

    // Magnitude of an operand; unsigned operands pass through. The most
    // negative value maps to 2^(DATA_W-1), which is exact as an unsigned word.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value,
                                                    input logic              is_signed);
        return cond_neg(value, is_signed & value[DATA_W-1]);
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  counter;

    // Datapath state: quotient/dividend shift register, partial remainder,
    // divisor magnitude and the sign/selection flags captured at acceptance.
    logic [DATA_W-1:0] q_reg;
    logic [DATA_W-1:0] rem_reg;
    logic [DATA_W-1:0] divisor;
    logic              op_rem;
    logic              neg_q;
    logic              neg_r;

    // Request decode.
    logic              is_div_op;
    logic              accept;
    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic              b_zero;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W-1:0] zero_div_res;

    // One restoring step and the sign-corrected final value.
    logic [DATA_W:0]   rem_shift;
    logic              q_bit;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] q_next;
    logic [DATA_W-1:0] final_res;
    logic              last_step;

    assign is_div_op = (operator_i[6:2] == DIV_GROUP);
    assign accept    = (state == ST_IDLE) && div_valid_i && is_div_op && !kill_i;
    assign op_signed = operator_i[0];
    assign a_neg     = op_signed & operand_a_i[DATA_W-1];
    assign b_neg     = op_signed & operand_b_i[DATA_W-1];
    assign b_zero    = (operand_b_i == '0);
    assign a_mag     = magnitude(operand_a_i, op_signed);
    assign b_mag     = magnitude(operand_b_i, op_signed);

    // Division by zero bypasses the iteration and the sign fix-up entirely.
    assign zero_div_res = operator_i[1] ? operand_a_i : '1;

    assign last_step = (state == ST_DIV) && (counter == CNT_W'(1));

    // Restoring step: bring in the next dividend bit, subtract when it fits.
    always_comb begin
        rem_shift = {rem_reg, q_reg[DATA_W-1]};
        q_bit     = (rem_shift >= {1'b0, divisor});
        rem_next  = q_bit ? DATA_W'(rem_shift - {1'b0, divisor}) : rem_shift[DATA_W-1:0];
        q_next    = {q_reg[DATA_W-2:0], q_bit};
        final_res = op_rem ? cond_neg(rem_next, neg_r) : cond_neg(q_next, neg_q);
    end

    // Control FSM: state, step counter and the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            counter        <= '0;
            div_ready_o    <= 1'b1;
            result_valid_o <= 1'b0;
        end else if (kill_i) begin
            state          <= ST_IDLE;
            counter        <= '0;
            div_ready_o    <= 1'b1;
            result_valid_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        div_ready_o <= 1'b0;
                        if (b_zero) begin
                            state          <= ST_FINISH;
                            counter        <= '0;
                            result_valid_o <= 1'b1;
                        end else begin
                            state   <= ST_DIV;
                            counter <= CNT_W'(DATA_W);
                        end
                    end
                end
                ST_DIV: begin
                    counter <= counter - CNT_W'(1);
                    if (last_step) begin
                        state          <= ST_FINISH;
                        result_valid_o <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (ex_ready_i) begin
                        state          <= ST_IDLE;
                        div_ready_o    <= 1'b1;
                        result_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    counter        <= '0;
                    div_ready_o    <= 1'b1;
                    result_valid_o <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: capture magnitudes and signs on acceptance, then iterate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            rem_reg <= '0;
            divisor <= '0;
            op_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            q_reg   <= a_mag;
            rem_reg <= '0;
            divisor <= b_mag;
            op_rem  <= operator_i[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
        end else if ((state == ST_DIV) && !kill_i) begin
            q_reg   <= q_next;
            rem_reg <= rem_next;
        end
    end

    // Result register: written once per operation and held through FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_o <= '0;
        end else if (accept && b_zero) begin
            result_o <= zero_div_res;
        end else if (last_step && !kill_i) begin
            result_o <= final_res;
        end
    end

endmodule

// File: tb/tb_riscv_alu_div_serial.sv
// Self-checking bench for riscv_alu_div_serial: a driver pushes expected
// results into a scoreboard queue, a monitor pops and compares them.
module tb_riscv_alu_div_serial;

    localparam int W = 32;
    localparam logic [6:0] OP_DIVU = 7'b0110000;
    localparam logic [6:0] OP_DIV  = 7'b0110001;
    localparam logic [6:0] OP_REMU = 7'b0110010;
    localparam logic [6:0] OP_REM  = 7'b0110011;

    logic         clk;
    logic         rst_n;
    logic         div_valid_i;
    logic [6:0]   operator_i;
    logic [W-1:0] operand_a_i;
    logic [W-1:0] operand_b_i;
    logic         div_ready_o;
    logic [W-1:0] result_o;
    logic         result_valid_o;
    logic         ex_ready_i;
    logic         kill_i;

    typedef struct {
        logic [31:0] res;
        int          t_acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    bit   hold_ready = 1'b0;
    int   pulse_cyc  = -1;

    riscv_alu_div_serial #(.DATA_W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .div_valid_i    (div_valid_i),
        .operator_i     (operator_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .div_ready_o    (div_ready_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .ex_ready_i     (ex_ready_i),
        .kill_i         (kill_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain 64-bit arithmetic (truncating division, remainder
    // follows the dividend), with the zero-divisor rule applied up front.
    function automatic logic [31:0] ref_div(input logic [6:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!div_ready_o && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!div_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: div_ready_o still %b after %0d cycles", div_ready_o, guard);
        end
    endtask

    // Called at a negedge; presents one request for a single cycle.
    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_result);
        exp_t e;
        wait_ready();
        div_valid_i = 1'b1;
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        if (expect_result) begin
            e.res   = ref_div(op, a, b);
            e.t_acc = cyc;
            e.lat   = (b == 32'd0) ? 1 : W + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        div_valid_i = 1'b0;
        operator_i  = 7'($urandom);
        operand_a_i = $urandom;
        operand_b_i = $urandom;
    endtask

    // Result consumer: random back-pressure, or a single scheduled pulse.
    initial begin
        ex_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_ready) ex_ready_i = (cyc == pulse_cyc);
            else            ex_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks value and latency on each new result, stability while held.
    initial begin
        logic        prev_valid;
        logic [31:0] held;
        exp_t        e;
        prev_valid = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (result_valid_o) begin
                    if (!prev_valid) begin
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_result: got %h with no request outstanding", result_o);
                        end else begin
                            e = sb_q.pop_front();
                            chk("result", result_o, e.res);
                            chk("latency", 32'(cyc - e.t_acc), 32'(e.lat));
                        end
                        held = result_o;
                    end else begin
                        chk("hold_stable", result_o, held);
                    end
                end
                prev_valid = result_valid_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          guard;
        int          c0;
        logic [6:0]  rop;
        logic [31:0] ra, rb;

        rst_n       = 1'b0;
        div_valid_i = 1'b0;
        operator_i  = '0;
        operand_a_i = '0;
        operand_b_i = '0;
        kill_i      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(div_ready_o), 32'd1);
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, including signed boundaries and zero divisors.
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        issue(OP_REMU, 32'd100, 32'd7, 1'b1);
        issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_REM,  32'd7, 32'hFFFF_FFFE, 1'b1);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIVU, 32'd5, 32'd0, 1'b1);
        issue(OP_DIV,  32'hFFFF_FFFB, 32'd0, 1'b1);
        issue(OP_REM,  32'hFFFF_FFFB, 32'd0, 1'b1);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // A non-divide opcode must leave the unit idle.
        wait_ready();
        div_valid_i = 1'b1;
        operator_i  = 7'b0000001;
        operand_a_i = 32'd50;
        operand_b_i = 32'd5;
        @(negedge clk);
        div_valid_i = 1'b0;
        chk("illegal_op_ignored", 32'(div_ready_o), 32'd1);

        // Long back-pressure in FINISH, then a single consume pulse.
        wait_ready();
        hold_ready = 1'b1;
        pulse_cyc  = -1;
        issue(OP_DIVU, 32'd1000, 32'd10, 1'b1);
        guard = 0;
        while (!result_valid_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("hold_reached_finish", 32'(result_valid_o), 32'd1);
        c0        = cyc;
        pulse_cyc = c0 + 10;
        repeat (10) @(negedge clk);
        chk("hold_valid_still_high", 32'(result_valid_o), 32'd1);
        chk("hold_not_ready", 32'(div_ready_o), 32'd0);
        @(negedge clk);
        chk("ready_after_pulse", 32'(div_ready_o), 32'd1);
        chk("valid_after_pulse", 32'(result_valid_o), 32'd0);
        hold_ready = 1'b0;

        // Flush in the 12th DIV cycle; a same-cycle request is dropped.
        issue(OP_DIVU, 32'd12345, 32'd3, 1'b0);
        repeat (11) @(negedge clk);
        kill_i      = 1'b1;
        div_valid_i = 1'b1;
        operator_i  = OP_DIVU;
        operand_a_i = 32'd9;
        operand_b_i = 32'd3;
        @(negedge clk);
        kill_i      = 1'b0;
        div_valid_i = 1'b0;
        chk("kill_valid_low", 32'(result_valid_o), 32'd0);
        chk("kill_back_idle", 32'(div_ready_o), 32'd1);
        repeat (40) @(negedge clk);
        chk("kill_no_result", 32'(result_valid_o), 32'd0);
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1);

        // Flush while idle drops the request.
        wait_ready();
        kill_i      = 1'b1;
        div_valid_i = 1'b1;
        operator_i  = OP_DIV;
        operand_a_i = 32'd20;
        operand_b_i = 32'd4;
        @(negedge clk);
        kill_i      = 1'b0;
        div_valid_i = 1'b0;
        chk("kill_drops_request", 32'(div_ready_o), 32'd1);
        repeat (5) @(negedge clk);
        chk("kill_drop_no_result", 32'(result_valid_o), 32'd0);

        // Asynchronous reset in the middle of an operation.
        issue(OP_REM, 32'hDEAD_BEEF, 32'd77, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(result_valid_o), 32'd0);
        chk("rst_mid_ready", 32'(div_ready_o), 32'd1);
        chk("rst_mid_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1);

        // Randomized operations across all four opcodes and operand classes.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rop = OP_DIVU;
                1: rop = OP_DIV;
                2: rop = OP_REMU;
                default: rop = OP_REM;
            endcase
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 1000);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = $urandom_range(1, 15);
                4: rb = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb, 1'b1);
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
